// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle 16-bit-ISA CPU with a parametrised datapath.
// Instructions are fetched over a req/valid handshake, so the instruction
// memory may have any latency.
// Optional feature macro: MIPS_BRANCH_EN. When it is defined, opcodes 8/9 are
// beq/bne. When it is undefined, they execute as nops.
module mips_multicycle_core #(
    parameter int unsigned    DATA_W   = 16,
    parameter int unsigned    PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              resetn,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_valid,
    input  logic [15:0]       imem_rdata,
    output logic [PC_W-1:0]   pc,
    output logic [15:0]       ir,
    output logic [DATA_W-1:0] alu_out,
    output logic              wb_valid,
    output logic [1:0]        wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              halted
);

    localparam int unsigned NREGS = 4;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    // Instruction field decode from the latched instruction
    logic [3:0]        op;
    logic [1:0]        rs;
    logic [1:0]        rt;
    logic [1:0]        rd;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [1:0]        dest;
    logic              is_alu;
    logic [DATA_W-1:0] alu_res;

    assign op      = ir[15:12];
    assign rs      = ir[11:10];
    assign rt      = ir[9:8];
    assign rd      = ir[7:6];
    assign imm_ext = DATA_W'($signed(ir[7:0]));
    assign dest    = (op == 4'h7) ? rt : rd;
    assign is_alu  = (op[3] == 1'b0);

    // Register file read: R0 is hardwired to zero
    assign rs_val = (rs == 2'd0) ? '0 : regs[rs];
    assign rt_val = (rt == 2'd0) ? '0 : regs[rt];

    assign imem_addr = pc;

    // ALU on the operands latched in DECODE
    always_comb begin
        alu_res = '0;
        case (op)
            4'h0:    alu_res = a_q + b_q;
            4'h1:    alu_res = a_q - b_q;
            4'h2:    alu_res = a_q & b_q;
            4'h3:    alu_res = a_q | b_q;
            4'h4:    alu_res = ~(a_q | b_q);
            4'h5:    alu_res = ~(a_q & b_q);
            4'h6:    alu_res = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
            4'h7:    alu_res = a_q + b_q;
            default: alu_res = '0;
        endcase
    end

`ifdef MIPS_BRANCH_EN
    // Branch target is relative to the already-incremented pc
    logic [PC_W-1:0] br_target;
    logic            br_taken;
    assign br_target = pc + (PC_W'($signed(ir[7:0])) << 1);
    assign br_taken  = ((op == 4'h8) && (a_q == b_q)) || ((op == 4'h9) && (a_q != b_q));
`endif

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            alu_out  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            wb_valid <= 1'b0;
            wb_reg   <= '0;
            wb_data  <= '0;
            halted   <= 1'b0;
            imem_req <= 1'b1;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            wb_valid <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (imem_valid) begin
                        ir       <= imem_rdata;
                        pc       <= pc + PC_W'(2);
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q <= rs_val;
                    b_q <= (op == 4'h7) ? imm_ext : rt_val;
                    if (op == 4'hF) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_alu) begin
                        alu_out  <= alu_res;
                        wb_reg   <= dest;
                        wb_data  <= alu_res;
                        wb_valid <= (dest != 2'd0);
                        state    <= S_WB;
                    end else begin
`ifdef MIPS_BRANCH_EN
                        if (br_taken) begin
                            pc <= br_target;
                        end
`endif
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_WB: begin
                    if (wb_valid) begin
                        regs[wb_reg] <= wb_data;
                    end
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_HALT: begin
                    halted   <= 1'b1;
                    imem_req <= 1'b0;
                end
                default: begin
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
            endcase
        end
    end

endmodule
